// File: rtl/pbus_pkg.sv
// Shared PBus definitions: request/byte-enable bit positions and the
// target handshake state encoding.
package pbus_pkg;

   localparam int REQ_VALID = 0;
   localparam int REQ_READ  = 1;

   localparam int BE_LO = 0;
   localparam int BE_HI = 1;

   localparam int WCNT_W = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      WAIT    = 3'd2,
      READY   = 3'd3,
      RELEASE = 3'd4
   } state_t;

endpackage

// File: rtl/pbus_target_ram.sv
// Word-organised 16-bit RAM with per-byte write enables and a registered read port.
// Each byte lane is its own array so block RAM byte-write inference stays simple.
module pbus_target_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [1:0]    we,
   input  logic [15:0]   wdata,
   input  logic          re,
   output logic [15:0]   rdata
);

   localparam int DEPTH = 2 ** AW;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk) begin
            if (we[gi]) begin
               mem[addr] <= wdata[8*gi +: 8];
            end
            if (re) begin
               rd_q <= mem[addr];
            end
         end

         assign rdata[8*gi +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/pbus_mem_target.sv
// PBus memory target: decodes one address-space window, runs the grant/wait/ready
// handshake and services byte-enabled writes and full-word reads of a local RAM.
module pbus_mem_target
   import pbus_pkg::*;
#(
   parameter logic        ASPACE      = 1'b0,
   parameter int          AW          = 8,
   parameter logic [15:1] BASE_WADDR  = 15'h0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:1] PBusAddr,
   input  logic [15:0] PBusDataIn,
   output logic [15:0] PBusDataOut,
   input  logic [1:0]  PBusReq,
   input  logic [1:0]  PBusBE,
   input  logic        PBusASpace,
   output logic        PBusGnt,
   output logic        PBusRdy,
   output logic        busy,
   output logic [15:0] access_cnt
);

   state_t              state_q, state_d;
   logic                gnt_q, gnt_d;
   logic                rdy_q, rdy_d;
   logic                busy_q, busy_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [1:0]          be_q, be_d;
   logic                rw_q, rw_d;
   logic [15:0]         wdata_q, wdata_d;

   logic                hit;
   logic [1:0]          ram_we;
   logic                ram_re;
   logic [15:0]         ram_rdata;

   assign hit = PBusReq[REQ_VALID]
              && (PBusASpace == ASPACE)
              && (PBusAddr[15:AW+1] == BASE_WADDR[15:AW+1]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      idx_d   = idx_q;
      be_d    = be_q;
      rw_d    = rw_q;
      wdata_d = wdata_q;
      ram_we  = 2'b00;
      ram_re  = 1'b0;

      case (state_q)
         IDLE: begin
            if (hit) begin
               idx_d   = PBusAddr[AW:1];
               be_d    = PBusBE;
               rw_d    = PBusReq[REQ_READ];
               wdata_d = PBusDataIn;
               state_d = GRANT;
            end
         end
         GRANT: begin
            wcnt_d  = WCNT_W'(WAIT_STATES);
            state_d = WAIT;
         end
         WAIT: begin
            // The memory access happens on the edge that leaves WAIT, so an
            // asynchronous reset before that edge cleanly drops the write.
            if (wcnt_q == '0) begin
               ram_we  = {be_q[BE_HI], be_q[BE_LO]} & {2{~rw_q}};
               ram_re  = rw_q;
               state_d = READY;
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
         end
         READY: begin
            cnt_d   = cnt_q + 16'd1;
            state_d = RELEASE;
         end
         RELEASE: begin
            if (!PBusReq[REQ_VALID]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      gnt_d  = (state_d == GRANT);
      rdy_d  = (state_d == READY);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         idx_q   <= '0;
         be_q    <= '0;
         rw_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         idx_q   <= idx_d;
         be_q    <= be_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
      end
   end

   pbus_target_ram #(
      .AW(AW)
   ) u_ram (
      .clk   (clk),
      .addr  (idx_q),
      .we    (ram_we),
      .wdata (wdata_q),
      .re    (ram_re),
      .rdata (ram_rdata)
   );

   // Gated to zero outside a read's ready cycle so several targets can be OR-combined.
   assign PBusDataOut = (rdy_q && rw_q) ? ram_rdata : 16'h0000;
   assign PBusGnt     = gnt_q;
   assign PBusRdy     = rdy_q;
   assign busy        = busy_q;
   assign access_cnt  = cnt_q;

endmodule

// File: tb/tb_pbus_mem_target.sv
// Three targets on one PBus (wait states 1, 0 and 15 in separate windows);
// stimulus queues expected responses, a negedge monitor checks them.
module tb_pbus_mem_target;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:1] PBusAddr;
   logic [15:0] PBusDataIn;
   logic [1:0]  PBusReq;
   logic [1:0]  PBusBE;
   logic        PBusASpace;

   logic [2:0]  gnt, rdy, busy;
   logic [15:0] dout [3];
   logic [15:0] acnt [3];

   typedef struct {
      int          dut;
      logic [15:0] data;
      int          gnt_cyc;
      int          rdy_cyc;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        mon_e;
   exp_t        ab_e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          exp_cnt [3];
   int          ab_k;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pbus_mem_target #(.ASPACE(1'b0), .AW(8), .BASE_WADDR(15'h0000), .WAIT_STATES(1)) u0 (
      .clk(clk), .rst(rst), .PBusAddr(PBusAddr), .PBusDataIn(PBusDataIn),
      .PBusDataOut(dout[0]), .PBusReq(PBusReq), .PBusBE(PBusBE), .PBusASpace(PBusASpace),
      .PBusGnt(gnt[0]), .PBusRdy(rdy[0]), .busy(busy[0]), .access_cnt(acnt[0]));

   pbus_mem_target #(.ASPACE(1'b0), .AW(8), .BASE_WADDR(15'h0100), .WAIT_STATES(0)) u1 (
      .clk(clk), .rst(rst), .PBusAddr(PBusAddr), .PBusDataIn(PBusDataIn),
      .PBusDataOut(dout[1]), .PBusReq(PBusReq), .PBusBE(PBusBE), .PBusASpace(PBusASpace),
      .PBusGnt(gnt[1]), .PBusRdy(rdy[1]), .busy(busy[1]), .access_cnt(acnt[1]));

   pbus_mem_target #(.ASPACE(1'b0), .AW(8), .BASE_WADDR(15'h0200), .WAIT_STATES(15)) u2 (
      .clk(clk), .rst(rst), .PBusAddr(PBusAddr), .PBusDataIn(PBusDataIn),
      .PBusDataOut(dout[2]), .PBusReq(PBusReq), .PBusBE(PBusBE), .PBusASpace(PBusASpace),
      .PBusGnt(gnt[2]), .PBusRdy(rdy[2]), .busy(busy[2]), .access_cnt(acnt[2]));

   // Monitor: grants must match the head of the queue; ready pops and checks it.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL gnt_unexpected dut%0d: grant at cyc %0d, required none", i, cyc);
               end else if (exp_q[0].dut != i || exp_q[0].gnt_cyc != cyc) begin
                  errors++;
                  $display("FAIL gnt_timing dut%0d: grant at cyc %0d, required dut%0d at cyc %0d",
                           i, cyc, exp_q[0].dut, exp_q[0].gnt_cyc);
               end
            end
            if (rdy[i]) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rdy_unexpected dut%0d: ready at cyc %0d, required none", i, cyc);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (mon_e.dut != i || mon_e.rdy_cyc != cyc || dout[i] !== mon_e.data) begin
                     errors++;
                     $display("FAIL rdy_resp dut%0d: cyc %0d data %h, required dut%0d cyc %0d data %h",
                              i, cyc, dout[i], mon_e.dut, mon_e.rdy_cyc, mon_e.data);
                  end else begin
                     $display("txn dut%0d ready cyc %0d data %h", i, cyc, dout[i]);
                  end
               end
            end else begin
               checks++;
               if (dout[i] !== 16'h0000) begin
                  errors++;
                  $display("FAIL dout_idle dut%0d: cyc %0d data %h, required 0000", i, cyc, dout[i]);
               end
            end
         end
      end
   end

   function automatic int ws_of(input int dut);
      return (dut == 0) ? 1 : ((dut == 1) ? 0 : 15);
   endfunction

   task automatic txn(input int dut, input logic [14:0] waddr, input bit rd,
                      input logic [1:0] be, input logic [15:0] wd,
                      input logic [15:0] exp_rd, input int hold, input bit early);
      exp_t e;
      bit   seen;
      @(posedge clk); #1;
      PBusAddr   = waddr;
      PBusDataIn = wd;
      PBusBE     = be;
      PBusASpace = 1'b0;
      PBusReq    = {rd, 1'b1};
      e.dut     = dut;
      e.data    = rd ? exp_rd : 16'h0000;
      e.gnt_cyc = cyc + 1;
      e.rdy_cyc = cyc + 3 + ws_of(dut);
      exp_q.push_back(e);
      exp_cnt[dut]++;
      if (early) begin
         // Drop the request and scramble the bus in the grant cycle.
         repeat (2) @(negedge clk);
         PBusReq    = 2'b00;
         PBusAddr   = 15'h7FFF;
         PBusDataIn = 16'hDEAD;
         PBusBE     = 2'b00;
      end
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (rdy[dut]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rdy_timeout dut%0d: no ready within 40 cycles, required one", dut);
      end
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
         checks++;
         if (busy[dut] !== 1'b1) begin
            errors++;
            $display("FAIL busy_release dut%0d: busy %b while request held, required 1", dut, busy[dut]);
         end
      end
      PBusReq = 2'b00;
      @(negedge clk);
      if (hold > 0) begin
         checks++;
         if (busy[dut] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_drop dut%0d: busy %b, required 0", dut, busy[dut]);
         end
      end
      @(negedge clk);
      checks++;
      if (busy[dut] !== 1'b0 || acnt[dut] !== 16'(exp_cnt[dut])) begin
         errors++;
         $display("FAIL access_cnt dut%0d: busy %b cnt %0d, required busy 0 cnt %0d",
                  dut, busy[dut], acnt[dut], exp_cnt[dut]);
      end
   endtask

   task automatic miss(input logic [14:0] waddr, input logic aspace);
      @(posedge clk); #1;
      PBusAddr   = waddr;
      PBusDataIn = 16'h9999;
      PBusBE     = 2'b11;
      PBusASpace = aspace;
      PBusReq    = 2'b01;
      repeat (20) begin
         @(negedge clk);
         checks++;
         if (gnt !== 3'b000 || rdy !== 3'b000 || busy !== 3'b000) begin
            errors++;
            $display("FAIL decode_miss addr %h as %b: gnt %b rdy %b busy %b, required all 0",
                     waddr, aspace, gnt, rdy, busy);
         end
      end
      $display("txn miss addr %h aspace %b ignored", waddr, aspace);
      PBusReq = 2'b00;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      PBusAddr   = '0;
      PBusDataIn = '0;
      PBusReq    = 2'b00;
      PBusBE     = 2'b00;
      PBusASpace = 1'b0;
      for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gnt[i] !== 1'b0 || rdy[i] !== 1'b0 || busy[i] !== 1'b0 ||
             dout[i] !== 16'h0000 || acnt[i] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state dut%0d: gnt %b rdy %b busy %b dout %h cnt %h, required all 0",
                     i, gnt[i], rdy[i], busy[i], dout[i], acnt[i]);
         end
      end
      rst = 1'b0;

      // Basic write then read
      txn(0, 15'h0005, 1'b0, 2'b11, 16'hBEEF, 16'h0000, 0, 1'b0);
      txn(0, 15'h0005, 1'b1, 2'b11, 16'h0000, 16'hBEEF, 0, 1'b0);

      // Byte enables, including a BE=00 read and a BE=00 write
      txn(0, 15'h0007, 1'b0, 2'b11, 16'h1234, 16'h0000, 0, 1'b0);
      txn(0, 15'h0007, 1'b0, 2'b10, 16'hAB00, 16'h0000, 0, 1'b0);
      txn(0, 15'h0007, 1'b0, 2'b01, 16'h00CD, 16'h0000, 0, 1'b0);
      txn(0, 15'h0007, 1'b1, 2'b00, 16'h0000, 16'hABCD, 0, 1'b0);
      txn(0, 15'h0007, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 0, 1'b0);
      txn(0, 15'h0007, 1'b1, 2'b11, 16'h0000, 16'hABCD, 0, 1'b0);

      // Decode: wrong address space, and an address outside every window
      miss(15'h0005, 1'b1);
      miss(15'h0400, 1'b0);
      txn(1, 15'h0100, 1'b0, 2'b11, 16'h1111, 16'h0000, 0, 1'b0);
      txn(1, 15'h0100, 1'b1, 2'b11, 16'h0000, 16'h1111, 0, 1'b0);

      // Request held after ready: single service
      txn(0, 15'h0005, 1'b1, 2'b11, 16'h0000, 16'hBEEF, 5, 1'b0);

      // Long wait-state target at the top of its window
      txn(2, 15'h02FF, 1'b0, 2'b11, 16'hCAFE, 16'h0000, 0, 1'b0);
      txn(2, 15'h02FF, 1'b1, 2'b11, 16'h0000, 16'hCAFE, 0, 1'b0);

      // Request dropped and bus scrambled during GRANT: transaction still completes
      txn(0, 15'h0009, 1'b0, 2'b11, 16'h7777, 16'h0000, 0, 1'b1);
      txn(0, 15'h0009, 1'b1, 2'b11, 16'h0000, 16'h7777, 0, 1'b0);

      // Reset during WAIT of a write drops it
      txn(0, 15'h0003, 1'b0, 2'b11, 16'h5555, 16'h0000, 0, 1'b0);
      @(posedge clk); #1;
      PBusAddr   = 15'h0003;
      PBusDataIn = 16'hAAAA;
      PBusBE     = 2'b11;
      PBusReq    = 2'b01;
      ab_k         = cyc;
      ab_e.dut     = 0;
      ab_e.data    = 16'h0000;
      ab_e.gnt_cyc = ab_k + 1;
      ab_e.rdy_cyc = ab_k + 4;
      exp_q.push_back(ab_e);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (gnt[0] !== 1'b0 || rdy[0] !== 1'b0 || busy[0] !== 1'b0 || acnt[0] !== 16'h0000) begin
         errors++;
         $display("FAIL reset_midtxn dut0: gnt %b rdy %b busy %b cnt %h, required all 0",
                  gnt[0], rdy[0], busy[0], acnt[0]);
      end
      PBusReq = 2'b00;
      ab_e = exp_q.pop_front();
      $display("txn dut0 write aborted by reset at cyc %0d", cyc);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
      txn(0, 15'h0003, 1'b1, 2'b11, 16'h0000, 16'h5555, 0, 1'b0);

      repeat (5) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
